// File: rtl/dps_utim64_pkg.sv
// rtl/dps_utim64_pkg.sv - shared types and constants for the UTIM64 host initiator
package dps_utim64_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_RD_WAIT    = 3'd2,
        ST_IRQ_ACK    = 3'd3,
        ST_FLAG_ISSUE = 3'd4,
        ST_FLAG_WAIT  = 3'd5
    } state_t;

    localparam int          TIMEOUT_DEFAULT   = 1024;
    localparam logic [4:0]  FLAG_ADDR_DEFAULT = 5'h1F;
    localparam logic        RW_WRITE          = 1'b1;
    localparam logic        RW_READ           = 1'b0;
    localparam int          FLAG_W            = 8;

endpackage

// File: rtl/dps_utim64_host_if.sv
// rtl/dps_utim64_host_if.sv - core-side command bus, device request bus and IRQ signals
interface dps_utim64_host_if;

    logic                                iCMD_VALID;
    logic                                oCMD_BUSY;
    logic                                iCMD_RW;
    logic [4:0]                          iCMD_ADDR;
    logic [31:0]                         iCMD_DATA;
    logic                                oRD_VALID;
    logic [31:0]                         oRD_DATA;
    logic                                oRD_ERR;
    logic                                oDEV_REQ_VALID;
    logic                                iDEV_REQ_BUSY;
    logic                                oDEV_REQ_RW;
    logic [4:0]                          oDEV_REQ_ADDR;
    logic [31:0]                         oDEV_REQ_DATA;
    logic                                iDEV_REQ_VALID;
    logic [31:0]                         iDEV_REQ_DATA;
    logic                                iDEV_IRQ_VALID;
    logic                                oDEV_IRQ_ACK;
    logic                                oIRQ_VALID;
    logic [dps_utim64_pkg::FLAG_W-1:0]   oIRQ_FLAGS;
    logic                                iIRQ_ACK;

    // Host side: drives the device bus and the core-side responses
    modport master (
        input  iCMD_VALID, iCMD_RW, iCMD_ADDR, iCMD_DATA,
        input  iDEV_REQ_BUSY, iDEV_REQ_VALID, iDEV_REQ_DATA,
        input  iDEV_IRQ_VALID, iIRQ_ACK,
        output oCMD_BUSY, oRD_VALID, oRD_DATA, oRD_ERR,
        output oDEV_REQ_VALID, oDEV_REQ_RW, oDEV_REQ_ADDR, oDEV_REQ_DATA,
        output oDEV_IRQ_ACK, oIRQ_VALID, oIRQ_FLAGS
    );

    // Environment side: core plus device
    modport slave (
        output iCMD_VALID, iCMD_RW, iCMD_ADDR, iCMD_DATA,
        output iDEV_REQ_BUSY, iDEV_REQ_VALID, iDEV_REQ_DATA,
        output iDEV_IRQ_VALID, iIRQ_ACK,
        input  oCMD_BUSY, oRD_VALID, oRD_DATA, oRD_ERR,
        input  oDEV_REQ_VALID, oDEV_REQ_RW, oDEV_REQ_ADDR, oDEV_REQ_DATA,
        input  oDEV_IRQ_ACK, oIRQ_VALID, oIRQ_FLAGS
    );

endinterface

// File: rtl/dps_utim64_host_wdt.sv
// rtl/dps_utim64_host_wdt.sv - clearable 16-bit response timeout counter
module dps_utim64_host_wdt #(
    parameter int P_TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    // tc fires on the enabled cycle that would bring the count up to P_TIMEOUT
    localparam logic [15:0] TC_VAL = 16'(P_TIMEOUT - 1);

    logic [15:0] count_q;

    // Count enabled wait cycles; clear wins so each transfer starts from zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign tc_o = en_i && (count_q == TC_VAL);

endmodule

// File: rtl/dps_utim64_host.sv
// rtl/dps_utim64_host.sv - UTIM64 request/IRQ initiator: command issue, read wait, IRQ flag fetch
module dps_utim64_host
    import dps_utim64_pkg::*;
#(
    parameter int         P_TIMEOUT   = TIMEOUT_DEFAULT,
    parameter logic [4:0] P_FLAG_ADDR = FLAG_ADDR_DEFAULT
) (
    input  logic              iCLOCK,
    input  logic              iRESET,
    dps_utim64_host_if.master bus
);

    state_t             state_q;
    logic               req_valid_q;
    logic               req_rw_q;
    logic [4:0]         req_addr_q;
    logic [31:0]        req_data_q;
    logic               rd_valid_q;
    logic [31:0]        rd_data_q;
    logic               rd_err_q;
    logic               irq_ack_q;
    logic               irq_valid_q;
    logic [FLAG_W-1:0]  irq_flags_q;

    logic               irq_take;
    logic               xfer;
    logic               wdt_en;
    logic               wdt_tc;

    // A device IRQ is only taken once the previous flags were consumed
    assign irq_take = bus.iDEV_IRQ_VALID && !irq_valid_q;
    assign xfer     = req_valid_q && !bus.iDEV_REQ_BUSY;
    assign wdt_en   = (state_q == ST_RD_WAIT) || (state_q == ST_FLAG_WAIT);

    dps_utim64_host_wdt #(
        .P_TIMEOUT (P_TIMEOUT)
    ) u_wdt (
        .clk_i (iCLOCK),
        .rst_i (iRESET),
        .clr_i (xfer),
        .en_i  (wdt_en),
        .tc_o  (wdt_tc)
    );

    // Main sequencer: command issue, read completion, IRQ ack and flag fetch
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state_q     <= ST_IDLE;
            req_valid_q <= 1'b0;
            req_rw_q    <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_err_q    <= 1'b0;
            irq_ack_q   <= 1'b0;
            irq_valid_q <= 1'b0;
            irq_flags_q <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            irq_ack_q  <= 1'b0;

            // Flags cannot be re-captured while pending, so the ack clear never races a capture
            if (bus.iIRQ_ACK && irq_valid_q) begin
                irq_valid_q <= 1'b0;
                irq_flags_q <= '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (irq_take) begin
                        irq_ack_q <= 1'b1;
                        state_q   <= ST_IRQ_ACK;
                    end else if (bus.iCMD_VALID) begin
                        req_rw_q    <= bus.iCMD_RW;
                        req_addr_q  <= bus.iCMD_ADDR;
                        req_data_q  <= bus.iCMD_DATA;
                        req_valid_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (xfer) begin
                        req_valid_q <= 1'b0;
                        state_q     <= (req_rw_q == RW_WRITE) ? ST_IDLE : ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (bus.iDEV_REQ_VALID) begin
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= bus.iDEV_REQ_DATA;
                        rd_err_q   <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (wdt_tc) begin
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= '0;
                        rd_err_q   <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_IRQ_ACK: begin
                    req_rw_q    <= RW_READ;
                    req_addr_q  <= P_FLAG_ADDR;
                    req_data_q  <= '0;
                    req_valid_q <= 1'b1;
                    state_q     <= ST_FLAG_ISSUE;
                end
                ST_FLAG_ISSUE: begin
                    if (xfer) begin
                        req_valid_q <= 1'b0;
                        state_q     <= ST_FLAG_WAIT;
                    end
                end
                ST_FLAG_WAIT: begin
                    // A zero flag byte is a spurious IRQ; a timeout is dropped silently
                    if (bus.iDEV_REQ_VALID) begin
                        if (bus.iDEV_REQ_DATA[FLAG_W-1:0] != '0) begin
                            irq_flags_q <= bus.iDEV_REQ_DATA[FLAG_W-1:0];
                            irq_valid_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end else if (wdt_tc) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.oCMD_BUSY      = (state_q != ST_IDLE) || irq_take;
    assign bus.oRD_VALID      = rd_valid_q;
    assign bus.oRD_DATA       = rd_data_q;
    assign bus.oRD_ERR        = rd_err_q;
    assign bus.oDEV_REQ_VALID = req_valid_q;
    assign bus.oDEV_REQ_RW    = req_rw_q;
    assign bus.oDEV_REQ_ADDR  = req_addr_q;
    assign bus.oDEV_REQ_DATA  = req_data_q;
    assign bus.oDEV_IRQ_ACK   = irq_ack_q;
    assign bus.oIRQ_VALID     = irq_valid_q;
    assign bus.oIRQ_FLAGS     = irq_flags_q;

endmodule
